// File: rtl/seq_det_param.sv
// rtl/seq_det_param.sv - run-time programmable serial pattern detector
// Mealy compare of the newest len bits against the active pattern, with a saturating match counter.
module seq_det_param #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 16,
  localparam int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               count_clr,
  input  logic               x,
  input  logic               x_valid,
  output logic               detect,
  output logic               detect_q,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LW-1:0]    LEN_MAX = LW'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [MAX_LEN-1:0] pat;
  logic [LW-1:0]      len;
  logic               ovl;
  logic [MAX_LEN-1:0] hist;
  logic [LW-1:0]      fill;

  logic [LW-1:0]      len_in;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] window;
  logic               sample;

  always_comb begin
    len_in = cfg_len;
    if (cfg_len == '0) begin
      len_in = LW'(1);
    end else if (cfg_len > LEN_MAX) begin
      len_in = LEN_MAX;
    end
  end

  // Only the low len bits of the window take part in the compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LW'(i) < len);
    end
  end

  assign window = {hist[MAX_LEN-2:0], x};
  assign sample = x_valid & ~cfg_load;
  assign detect = sample & (fill >= len - LW'(1)) & ((window & mask) == (pat & mask));

  always_ff @(posedge clk) begin
    if (reset) begin
      pat  <= MAX_LEN'(5);
      len  <= LW'(3);
      ovl  <= 1'b1;
      hist <= '0;
      fill <= '0;
    end else if (cfg_load) begin
      pat  <= cfg_pattern;
      len  <= len_in;
      ovl  <= cfg_overlap;
      fill <= '0;
    end else if (x_valid) begin
      hist <= window;
      if (detect && !ovl) begin
        fill <= '0;
      end else if (fill != LEN_MAX) begin
        fill <= fill + LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      detect_q    <= 1'b0;
      match_count <= '0;
    end else begin
      detect_q <= detect;
      if (count_clr) begin
        match_count <= '0;
      end else if (detect && match_count != CNT_MAX) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_det_param.sv
// tb/tb_seq_det_param.sv - table-driven bench for seq_det_param
// Each vector drives one cycle and checks detect, detect_q and match_count before the next edge.
module tb_seq_det_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       count_clr;
  logic       x;
  logic       x_valid;
  logic       detect;
  logic       detect_q;
  logic [3:0] match_count;

  seq_det_param #(.MAX_LEN(8), .CNT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .count_clr   (count_clr),
    .x           (x),
    .x_valid     (x_valid),
    .detect      (detect),
    .detect_q    (detect_q),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ld;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       clr;
    logic       xb;
    logic       xv;
    logic       ed;
    logic       edq;
    logic [3:0] ecnt;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;
  logic [7:0] p3 = 8'hD3;
  int   gaps[8] = '{1, 2, 3, 1, 2, 3, 1, 1};

  task automatic add(input logic rst, input logic ld, input logic [7:0] pat, input logic [3:0] len,
                     input logic ovl, input logic clr, input logic xb, input logic xv,
                     input logic ed, input logic edq, input logic [3:0] ecnt);
    vec_t v;
    v.rst = rst; v.ld = ld; v.pat = pat; v.len = len; v.ovl = ovl; v.clr = clr;
    v.xb = xb; v.xv = xv; v.ed = ed; v.edq = edq; v.ecnt = ecnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic rst, input logic ld, input logic [7:0] pat, input logic [3:0] len,
                       input logic ovl, input logic clr, input logic xb, input logic xv);
    reset = rst; cfg_load = ld; cfg_pattern = pat; cfg_len = len;
    cfg_overlap = ovl; count_clr = clr; x = xb; x_valid = xv;
  endtask

  initial begin
    // default config 101 overlapping: 1,0,1,0,1
    add(0,0,8'h00,0,0,0, 1,1, 0,0,0);
    add(0,0,8'h00,0,0,0, 0,1, 0,0,0);
    add(0,0,8'h00,0,0,0, 1,1, 1,0,0);
    add(0,0,8'h00,0,0,0, 0,1, 0,1,1);
    add(0,0,8'h00,0,0,0, 1,1, 1,0,1);
    add(0,0,8'h00,0,0,0, 0,0, 0,1,2);
    // non-overlapping 101; sample in the load cycle is dropped, count untouched
    add(0,1,8'h05,3,0,0, 1,1, 0,0,2);
    add(0,0,8'h00,0,0,1, 0,0, 0,0,2);
    add(0,0,8'h00,0,0,0, 1,1, 0,0,0);
    add(0,0,8'h00,0,0,0, 0,1, 0,0,0);
    add(0,0,8'h00,0,0,0, 1,1, 1,0,0);
    add(0,0,8'h00,0,0,0, 0,1, 0,1,1);
    add(0,0,8'h00,0,0,0, 1,1, 0,0,1);
    add(0,0,8'h00,0,0,0, 0,1, 0,0,1);
    add(0,0,8'h00,0,0,0, 1,1, 1,0,1);
    add(0,0,8'h00,0,0,0, 0,0, 0,1,2);
    // 8-bit pattern with idle gaps between samples
    add(0,1,8'hD3,8,1,0, 0,0, 0,0,2);
    for (int b = 0; b < 8; b++) begin
      add(0,0,8'h00,0,0,0, p3[7-b],1, b == 7, 0, 2);
      for (int g = 0; g < gaps[b]; g++)
        add(0,0,8'h00,0,0,0, 0,0, 0, (b == 7) && (g == 0), (b == 7) ? 4'd3 : 4'd2);
    end
    // len 0 behaves as len 1, pattern bit 1
    add(0,1,8'h01,0,1,0, 0,0, 0,0,3);
    add(0,0,8'h00,0,0,0, 1,1, 1,0,3);
    add(0,0,8'h00,0,0,0, 1,1, 1,1,4);
    add(0,0,8'h00,0,0,0, 0,1, 0,1,5);
    add(0,0,8'h00,0,0,0, 1,1, 1,0,5);
    add(0,0,8'h00,0,0,0, 0,0, 0,1,6);
    // pattern 11 overlapping: saturation, then clear beats a detect
    add(0,1,8'h03,2,1,0, 0,0, 0,0,6);
    add(0,0,8'h00,0,0,1, 0,0, 0,0,6);
    for (int i = 1; i <= 20; i++)
      add(0,0,8'h00,0,0,0, 1,1, i >= 2, i >= 3, (i >= 2) ? ((i - 2 > 15) ? 4'd15 : 4'(i - 2)) : 4'd0);
    add(0,0,8'h00,0,0,1, 1,1, 1,1,15);
    add(0,0,8'h00,0,0,0, 0,0, 0,1,0);
    // reset discards partial match and restores 101; cfg_load masks a completing bit
    add(0,0,8'h00,0,0,0, 1,1, 1,0,0);
    add(1,0,8'h00,0,0,0, 0,0, 0,1,1);
    add(0,0,8'h00,0,0,0, 1,1, 0,0,0);
    add(0,0,8'h00,0,0,0, 0,1, 0,0,0);
    add(1,0,8'h00,0,0,0, 0,0, 0,0,0);
    add(0,0,8'h00,0,0,0, 1,1, 0,0,0);
    add(0,0,8'h00,0,0,0, 0,1, 0,0,0);
    add(0,1,8'h05,3,1,0, 1,1, 0,0,0);
    add(0,0,8'h00,0,0,0, 0,1, 0,0,0);
    add(0,0,8'h00,0,0,0, 1,1, 0,0,0);
    add(0,0,8'h00,0,0,0, 0,1, 0,0,0);
    add(0,0,8'h00,0,0,0, 1,1, 1,0,0);
    add(0,0,8'h00,0,0,0, 0,0, 0,1,1);

    drive(1,0,8'h00,0,0,0,0,0);
    repeat (2) @(posedge clk);
    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].rst, vecs[k].ld, vecs[k].pat, vecs[k].len, vecs[k].ovl, vecs[k].clr, vecs[k].xb, vecs[k].xv);
      #1;
      chk($sformatf("v%0d detect", k), 16'(detect), 16'(vecs[k].ed));
      chk($sformatf("v%0d detect_q", k), 16'(detect_q), 16'(vecs[k].edq));
      chk($sformatf("v%0d match_count", k), 16'(match_count), 16'(vecs[k].ecnt));
    end

    // len 15 clamps to 8: all-ones non-overlapping, one detect on the 8th sample only
    @(negedge clk);
    drive(0,1,8'hFF,4'd15,0,0,1,1);
    #1 chk("clamp load detect", 16'(detect), 16'd0);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      drive(0,0,8'h00,0,0,0,1,1);
      #1 chk($sformatf("clamp s%0d detect", i), 16'(detect), 16'(i == 8));
    end
    chk("clamp detect_q", 16'(detect_q), 16'd1);
    chk("clamp match_count", 16'(match_count), 16'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_det_param.md
# seq_det_param

Parametrised, run-time-programmable serial pattern detector. It generalises the team's fixed "101" Mealy detector to any pattern of 1..MAX_LEN bits, with selectable overlapping or non-overlapping matching, a sample-valid qualifier, a registered detect copy and a saturating match counter. It sits on a 1-bit serial stream, such as a deserialiser output or a UART bit stream, and feeds sync or framing logic.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (≥2).
- CNT_W, 16: match counter width.
- LW, $clog2(MAX_LEN+1): width of the length field (derived, not overridable).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- cfg_load  in  1  one-cycle pulse; latches cfg_pattern, cfg_len and cfg_overlap into the active config.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  in  LW  pattern length. 0 is treated as 1; values above MAX_LEN are treated as MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping.
- count_clr  in  1  clears match_count.
- x  in  1  serial data bit.
- x_valid  in  1  x is a sample this cycle.
- detect  out  1  Mealy match output (combinational).
- detect_q  out  1  detect registered, one cycle later.
- match_count  out  CNT_W  saturating count of detect pulses.

## Operation
- Active config registers: pat, len, ovl. Reset values: pat = 'b101, len = 3, ovl = 1. This reproduces the legacy 101 overlapping detector.
- History registers:
  - hist[MAX_LEN-1:0], shift register, newest bit at [0].
  - fill in 0..MAX_LEN, the number of valid history bits.
- Match condition, using the active config only (never the raw cfg_* inputs):
  - detect = x_valid & !cfg_load & (fill ≥ len-1) & ({hist[len-2:0], x} == pat[len-1:0]).
  - For len = 1: detect = x_valid & !cfg_load & (x == pat[0]).
- When x_valid = 1 and cfg_load = 0:
  - hist <= {hist[MAX_LEN-2:0], x}.
  - fill <= min(fill+1, MAX_LEN).
  - If detect = 1 and ovl = 0: fill <= 0, so no bit of the matched window is reused.
- When x_valid = 0: hist and fill hold and detect = 0. Gaps between samples do not break a partial match.
- When cfg_load = 1: the active config is loaded, fill <= 0, and any x sample in that cycle is dropped (cfg_load wins). match_count is not affected.
- match_count:
  - Increments by 1 on each cycle with detect = 1.
  - Holds at 2^CNT_W-1 (saturates, never wraps).
  - count_clr = 1 forces it to 0, even if detect = 1 in the same cycle.
- detect_q <= detect every cycle.
- Reset:
  - fill = 0, hist = 0, and the active config takes its reset values.
  - detect = 0 (since fill = 0 and len = 3), detect_q = 0, match_count = 0.
  - A partial match in progress is discarded.

## Timing
- detect is combinational, asserted in the same cycle as the sample that completes the pattern. Path: x → compare → detect.
- detect_q and the match_count update are visible one cycle after detect.
- A config change takes effect from the first x_valid cycle after the cfg_load cycle.
- After cfg_load or reset, the earliest possible detect is on the len-th valid sample.
- Non-overlap mode: the earliest next detect is len valid samples after a match.
- Overlap mode: a next detect can follow after as few as 1 valid sample (e.g. pattern 11).
- reset takes priority over cfg_load, count_clr and x_valid.

## Test plan
- Reset defaults, x_valid = 1 every cycle, x = 1,0,1,0,1 → detect high on samples 3 and 5. detect_q high on the following cycles. match_count = 2.
- Load cfg_overlap = 0 with pattern 101, len 3; stream 1,0,1,0,1,0,1 → detect on samples 3 and 7 only. match_count = 2.
- Load pattern 8'b11010011, len 8, overlap 1. Feed the pattern with x_valid = 0 gaps of 1–3 cycles between bits → exactly one detect, on the 8th valid sample. detect = 0 in every gap cycle.
- Load len = 0 with pattern[0] = 1 (treated as len 1); stream 1,1,0,1 → detect on samples 1, 2 and 4.
- CNT_W = 4, pattern 11, overlap: 20 consecutive 1s → match_count saturates at 15. Then assert count_clr together with a detect → match_count = 0.
- Default config: feed 1,0, then reset, then 1 → no detect. Assert cfg_load in the same cycle as a completing 1 → no detect, and the sample is dropped.
